// File: rtl/fp_sum_collector.sv
// Result collector for the pipelined FP summator: tracks issued operand pairs,
// captures results at a fixed latency and buffers them behind ready/valid.
module fp_sum_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_vld_i,
    output logic                       issue_rdy_o,
    input  logic [31:0]                sum_i,
    input  logic [1:0]                 sum_status_i,
    output logic                       res_vld_o,
    input  logic                       res_rdy_i,
    output logic [31:0]                res_data_o,
    output logic [1:0]                 res_status_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int OW = ((CW > IW) ? CW : IW) + 1;

    logic [LATENCY-1:0] tokens;
    logic [IW-1:0]      inflight;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               err;
    logic [33:0]        mem [DEPTH];

    logic          cap;
    logic          accept;
    logic          pop;
    logic          full;
    logic          push;
    logic          viol;
    logic [OW-1:0] occ;

    assign cap    = tokens[LATENCY-1];
    assign occ    = OW'(inflight) + OW'(count);
    assign issue_rdy_o = occ < OW'(DEPTH);
    assign accept = issue_vld_i & issue_rdy_o;
    assign full   = count == CW'(DEPTH);
    assign pop    = res_vld_o & res_rdy_i;
    // A pop in the same cycle frees the slot, so a capture at full is legal then.
    assign push   = cap & (~full | pop);
    assign viol   = (issue_vld_i & ~issue_rdy_o) | (cap & full & ~pop);

    assign res_vld_o    = count != '0;
    assign res_data_o   = mem[rd_ptr][31:0];
    assign res_status_o = mem[rd_ptr][33:32];
    assign count_o      = count;
    assign err_o        = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tokens   <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            tokens[0] <= accept;
            for (int i = 1; i < LATENCY; i++) tokens[i] <= tokens[i-1];
            inflight <= inflight + IW'(accept) - IW'(cap);
            if (push) begin
                mem[wr_ptr] <= {sum_status_i, sum_i};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (viol) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_sum_collector.sv
// Randomized scoreboard bench for fp_sum_collector with an occupancy-level
// reference model and a behavioural summator pipeline.
module tb_fp_sum_collector;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int NEVER = 32'h7fffffff;

    logic        clk = 0;
    logic        rst = 0;
    logic        issue_vld = 0;
    logic        issue_rdy;
    logic [31:0] sum = 0;
    logic [1:0]  sum_status = 0;
    logic        res_vld;
    logic        res_rdy = 0;
    logic [31:0] res_data;
    logic [1:0]  res_status;
    logic [3:0]  count;
    logic        err;

    fp_sum_collector #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_vld_i(issue_vld), .issue_rdy_o(issue_rdy),
        .sum_i(sum), .sum_status_i(sum_status),
        .res_vld_o(res_vld), .res_rdy_i(res_rdy),
        .res_data_o(res_data), .res_status_o(res_status),
        .count_o(count), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        int          ie;
    } ent_t;

    ent_t        q[$];
    logic [33:0] sched[int];
    int          cyc = 0;
    int          err_edge = NEVER;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Monitor: expected state comes from the list of un-popped issues.
    always @(negedge clk) begin
        if (!rst) begin
            int n_occ;
            int n_cap;
            n_occ = 0;
            n_cap = 0;
            foreach (q[i]) begin
                if (q[i].ie <= cyc) n_occ++;
                if (q[i].ie + LAT <= cyc) n_cap++;
            end
            chk("issue_rdy", 64'(issue_rdy), 64'(n_occ < DEPTH));
            chk("count", 64'(count), 64'(n_cap));
            chk("res_vld", 64'(res_vld), 64'(n_cap > 0));
            chk("err", 64'(err), 64'(cyc >= err_edge));
            if (n_cap > 0 && res_rdy) begin
                chk("res_data", 64'(res_data), 64'(q[0].d));
                chk("res_status", 64'(res_status), 64'(q[0].s));
                void'(q.pop_front());
            end
        end
    end

    // One cycle of stimulus, called just after a rising edge.
    task automatic step(input bit want, input bit rdy, input logic [31:0] d,
                        input logic [1:0] s, input bit viol);
        bit allowed;
        ent_t e;
        allowed = q.size() < DEPTH;
        res_rdy = rdy;
        issue_vld = 0;
        if (want && allowed) begin
            issue_vld = 1;
            e.d = d;
            e.s = s;
            e.ie = cyc + 1;
            q.push_back(e);
            sched[cyc + 1 + LAT] = {s, d};
        end else if (want && viol) begin
            issue_vld = 1;
            if (err_edge == NEVER) err_edge = cyc + 1;
        end
        if (sched.exists(cyc + 1)) begin
            {sum_status, sum} = sched[cyc + 1];
            sched.delete(cyc + 1);
        end else begin
            sum = $urandom;
            sum_status = 2'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3;
        rst = 1;
        issue_vld = 0;
        q.delete();
        sched.delete();
        err_edge = NEVER;
        #1;
        chk("rst_issue_rdy", 64'(issue_rdy), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_res_vld", 64'(res_vld), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_data", 64'({res_status, res_data}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        step(0, 0, 0, 0, 0);

        step(1, 0, 32'h40400000, 2'b01, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        for (int i = 1; i <= 8; i++) step(1, 0, 32'(i), 2'(i), 0);
        repeat (5) step(0, 0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 20; i++) step(1, 1, $urandom, 2'($urandom), 0);
        repeat (6) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 $urandom, 2'($urandom), 0);
        repeat (12) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 8; i++) step(1, 0, $urandom, 2'($urandom), 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 0, 32'hdeadbeef, 2'b11, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 3; i++) step(1, 0, $urandom, 2'($urandom), 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        repeat (8) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 100; i++)
            step(($urandom % 2) != 0, ($urandom % 4) != 0,
                 $urandom, 2'($urandom), 0);

        for (int i = 0; i < 50 && q.size() != 0; i++) step(0, 1, 0, 0, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_sum_collector.md
# fp_sum_collector

Receiving end of the pipelined FP summator's result interface. The summator has no output valid or backpressure. This block tracks every operand pair issued to it, captures `answer_o`/`num_status_o` at the fixed pipeline latency, and buffers each result in a FIFO behind a ready/valid port. It also gives the issuer a credit signal, so no result is ever dropped.

## Interface
- `LATENCY`, default 4: clock edges from the edge that samples an issue to the edge at which its result is sampled on `sum_i`. Must be ≥1.
- `DEPTH`, default 8: number of result FIFO entries. Must be a power of two and ≥2.
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `issue_vld_i` in 1: the issuer drives an operand pair into the summator this cycle. This is the same net as the summator's `vld_i`.
- `issue_rdy_o` out 1: a credit is available. The issuer may assert `issue_vld_i` only while this is 1.
- `sum_i` in 32: summator `answer_o`.
- `sum_status_i` in 2: summator `num_status_o`.
- `res_vld_o` out 1: the FIFO head is valid.
- `res_rdy_i` in 1: the consumer accepts the head.
- `res_data_o` out 32: head result.
- `res_status_o` out 2: head status.
- `count_o` out $clog2(DEPTH+1): FIFO entries currently stored.
- `err_o` out 1: sticky protocol-violation flag.

## Operation
- **Token line:** a LATENCY-bit shift register. Bit 0 loads `issue_vld_i & issue_rdy_o` and shifts every cycle. The top bit (`cap`) marks the edge at which `{sum_status_i, sum_i}` is written into the FIFO.
- **Occupancy:** `inflight` (set bits in the token line, held as a counter) plus `count_o`.
  - `issue_rdy_o = (inflight + count_o) < DEPTH`, derived from registers only.
  - No combinational path from `issue_vld_i` or `res_rdy_i` to `issue_rdy_o`.
- **FIFO:**
  - Write pointer and read pointer of width $clog2(DEPTH); both wrap modulo DEPTH.
  - Push when `cap`. Pop when `res_vld_o & res_rdy_i`.
  - `res_vld_o = (count_o != 0)`. `res_data_o`/`res_status_o` show `mem[rd_ptr]` (first-word fall-through).
- **Counter updates per edge:**
  - `inflight`: +1 on accepted issue, −1 on `cap`. Both in the same cycle gives no change.
  - `count_o`: +1 on push, −1 on pop. Both in the same cycle gives no change, and both pointers advance.
- **Push when full:** cannot occur under credit rules. If it does (`cap` while `count_o==DEPTH` and no pop), the result is dropped and `err_o` is set.
- **Issue without credit:** `issue_vld_i` while `issue_rdy_o==0` is a violation.
  - The token is not tracked.
  - `err_o` is set.
  - Counters are unchanged.
- **`err_o` clearing:** cleared only by reset.
- **Ordering:** results leave in issue order. No reordering, no coalescing.

## Timing
- **Reset values** (immediate on `rst_i`, held while high):
  - token line, `inflight`, pointers, `count_o`: 0.
  - `res_vld_o`, `err_o`: 0.
  - `res_data_o`, `res_status_o`: 0, because the memory is also cleared.
  - `issue_rdy_o`: 1.
- **Capture latency:** an issue sampled at edge k has its result sampled from `sum_i` at edge k+LATENCY. `res_vld_o` for that result can rise after edge k+LATENCY at the earliest (empty FIFO).
- **Throughput:** one issue and one result per cycle sustained when `res_rdy_i`=1.
- **Credit return:**
  - A pop at edge m raises `issue_rdy_o` after edge m.
  - Credits are never returned early on `cap`, since capture moves an item from in-flight to stored and occupancy is unchanged.
- **Simultaneous events:**
  - Issue, cap and pop in one cycle are all legal and are processed together.
  - At DEPTH-1 occupancy, an issue and a pop in the same cycle leave `issue_rdy_o`=1.
- **Mid-operation reset:**
  - In-flight tokens and stored results are discarded.
  - No `res_vld_o` pulse follows for them, even though the summator's pipeline may still emit values.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle → all outputs take their reset values before the next edge; `issue_rdy_o`=1, `count_o`=0.
- **Single result:** issue once at edge k; model drives `sum_i`=0x40400000, `sum_status_i`=2'b01 only for the edge k+4 sample → `res_vld_o` rises after edge k+4 with data 0x40400000 and status 01; popping it returns `count_o` to 0.
- **Fill with backpressure:** `res_rdy_i`=0, issue 0x1..0x8 tagged results back-to-back → `issue_rdy_o` falls after the 8th issue; `count_o` reaches 8 four edges later. Then `res_rdy_i`=1 → 0x1..0x8 emerge in order on consecutive cycles, pointers wrap, and `issue_rdy_o` returns after the first pop.
- **Streaming:** 20 consecutive issues with `res_rdy_i`=1 → `issue_rdy_o` stays 1; 20 results in order; `count_o` ≤1; `err_o`=0.
- **Violation:** at full occupancy, pulse `issue_vld_i` → `err_o`=1 and stays 1; no extra result appears; `count_o` is unchanged.
- **Mid-flight reset:** issue 3, reset one cycle later, keep driving `sum_i` → `res_vld_o` stays 0; `count_o`=0.
